// File: rtl/or_stim_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : or_stim_sequencer
// Description : Stimulus sequencer for a downstream four-input OR stage.
//               A start request latches a pattern set (mode) and a per-pattern
//               hold time (dwell), then steps through the patterns, holding
//               each for dwell+1 cycles. Alongside each pattern it drives the
//               expected OR result. A one-cycle done pulse follows a complete
//               sequence. An abort or reset returns the block to idle without
//               a done pulse.
// Ports       : clk     - single clock, rising edge
//               rst     - synchronous active-high reset
//               start   - begin a sequence (sampled only when idle)
//               abort   - terminate a running sequence
//               mode    - 00/11 binary, 01 walking-one, 10 Gray
//               dwell   - cycles per pattern minus one
//               a,b,c,d - pattern bits 0..3
//               exp_or  - a|b|c|d of the current pattern
//               valid   - a..d carry a sequence pattern
//               busy    - sequence running
//               done    - one-cycle completion pulse
//               idx     - index of the current pattern
// Revision    : 1.0 - initial release
// ============================================================================
module or_stim_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [1:0]         mode,
    input  logic [DWELL_W-1:0] dwell,
    output logic               a,
    output logic               b,
    output logic               c,
    output logic               d,
    output logic               exp_or,
    output logic               valid,
    output logic               busy,
    output logic               done,
    output logic [3:0]         idx
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [1:0] c_MODE_WALK = 2'b01;
    localparam logic [1:0] c_MODE_GRAY = 2'b10;

    // Pattern generator shared by the first pattern (from the live mode input)
    // and subsequent patterns (from the latched mode).
    function automatic logic [3:0] f_pattern(input logic [1:0] m, input logic [3:0] i);
        logic [3:0] p;
        case (m)
            c_MODE_WALK: p = 4'b0001 << i[1:0];
            c_MODE_GRAY: p = i ^ (i >> 1);
            default:     p = i;
        endcase
        return p;
    endfunction

    logic [1:0]         r_state_q, w_state_d;
    logic [1:0]         r_mode_q,  w_mode_d;
    logic [DWELL_W-1:0] r_dwell_q, w_dwell_d;
    logic [DWELL_W-1:0] r_cnt_q,   w_cnt_d;
    logic [3:0]         r_idx_q,   w_idx_d;
    logic [3:0]         r_pat_q,   w_pat_d;
    logic               r_exp_or_q, w_exp_or_d;
    logic               r_valid_q, w_valid_d;
    logic               r_busy_q,  w_busy_d;
    logic               r_done_q,  w_done_d;
    logic [3:0]         w_last_idx;

    // Walking-one has four patterns; every other set has sixteen.
    assign w_last_idx = (r_mode_q == c_MODE_WALK) ? 4'd3 : 4'd15;

    always_comb begin
        // Outputs default to the all-zero idle image; only an active RUN
        // cycle drives anything else.
        w_state_d = r_state_q;
        w_mode_d  = r_mode_q;
        w_dwell_d = r_dwell_q;
        w_cnt_d   = r_cnt_q;
        w_idx_d   = 4'd0;
        w_pat_d   = 4'd0;
        w_valid_d = 1'b0;
        w_busy_d  = 1'b0;
        w_done_d  = 1'b0;

        case (r_state_q)
            c_IDLE: begin
                if (start && !abort) begin
                    w_state_d = c_RUN;
                    w_mode_d  = mode;
                    w_dwell_d = dwell;
                    w_cnt_d   = '0;
                    w_pat_d   = f_pattern(mode, 4'd0);
                    w_valid_d = 1'b1;
                    w_busy_d  = 1'b1;
                end
            end

            c_RUN: begin
                if (abort) begin
                    w_state_d = c_IDLE;
                    w_cnt_d   = '0;
                end else if (r_cnt_q == r_dwell_q) begin
                    // Final dwell cycle of this pattern: advance or finish.
                    w_cnt_d = '0;
                    if (r_idx_q == w_last_idx) begin
                        w_state_d = c_DONE;
                        w_done_d  = 1'b1;
                    end else begin
                        w_idx_d   = r_idx_q + 4'd1;
                        w_pat_d   = f_pattern(r_mode_q, r_idx_q + 4'd1);
                        w_valid_d = 1'b1;
                        w_busy_d  = 1'b1;
                    end
                end else begin
                    w_cnt_d   = r_cnt_q + 1'b1;
                    w_idx_d   = r_idx_q;
                    w_pat_d   = r_pat_q;
                    w_valid_d = 1'b1;
                    w_busy_d  = 1'b1;
                end
            end

            c_DONE: begin
                w_state_d = c_IDLE;
            end

            default: begin
                w_state_d = c_IDLE;
                w_cnt_d   = '0;
            end
        endcase

        // Derived from the next pattern so it is registered on the same edge.
        w_exp_or_d = |w_pat_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= c_IDLE;
            r_mode_q   <= 2'b00;
            r_dwell_q  <= '0;
            r_cnt_q    <= '0;
            r_idx_q    <= 4'd0;
            r_pat_q    <= 4'd0;
            r_exp_or_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_busy_q   <= 1'b0;
            r_done_q   <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_mode_q   <= w_mode_d;
            r_dwell_q  <= w_dwell_d;
            r_cnt_q    <= w_cnt_d;
            r_idx_q    <= w_idx_d;
            r_pat_q    <= w_pat_d;
            r_exp_or_q <= w_exp_or_d;
            r_valid_q  <= w_valid_d;
            r_busy_q   <= w_busy_d;
            r_done_q   <= w_done_d;
        end
    end

    assign a      = r_pat_q[0];
    assign b      = r_pat_q[1];
    assign c      = r_pat_q[2];
    assign d      = r_pat_q[3];
    assign exp_or = r_exp_or_q;
    assign valid  = r_valid_q;
    assign busy   = r_busy_q;
    assign done   = r_done_q;
    assign idx    = r_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_or_stim_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_or_stim_sequencer
// Description : Self-checking bench for or_stim_sequencer. A reference model
//               tracks elapsed run time and derives the expected pattern index
//               as elapsed / (dwell+1); every cycle's outputs are compared.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_or_stim_sequencer;

    localparam int DWELL_W = 8;

    logic               clk = 1'b0;
    logic               rst, start, abort;
    logic [1:0]         mode;
    logic [DWELL_W-1:0] dwell;
    logic               a, b, c, d, exp_or, valid, busy, done;
    logic [3:0]         idx;

    int n_checks = 0;
    int n_errors = 0;

    // Model: m_run = sequence active, m_done = done cycle, m_t = cycles
    // elapsed since the first pattern appeared.
    bit m_run, m_done;
    int m_t, m_mode, m_dwell;

    // Observation bookkeeping for scenario-level checks.
    int done_cnt, busy_cnt;
    logic [3:0] prev_pat;
    bit         prev_valid;
    int         gray_bad;

    always #5 clk = ~clk;

    or_stim_sequencer #(.DWELL_W(DWELL_W)) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
        .dwell(dwell), .a(a), .b(b), .c(c), .d(d), .exp_or(exp_or),
        .valid(valid), .busy(busy), .done(done), .idx(idx)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int n_of(input int md);
        return (md == 1) ? 4 : 16;
    endfunction

    function automatic logic [3:0] pat_of(input int md, input int i);
        int p;
        if (md == 1)      p = 1 << i;
        else if (md == 2) p = i ^ (i >> 1);
        else              p = i;
        return p[3:0];
    endfunction

    // One clock: advance the model on the edge using the inputs present at
    // that edge, then compare the full output image shortly afterwards.
    task automatic cyc();
        logic [11:0] e, o;
        int          k;
        logic [3:0]  p, cur;
        @(posedge clk);
        if (rst) begin
            m_run = 0; m_done = 0;
        end else if (m_run) begin
            if (abort) m_run = 0;
            else begin
                m_t++;
                if (m_t == n_of(m_mode) * (m_dwell + 1)) begin
                    m_run = 0; m_done = 1;
                end
            end
        end else if (m_done) begin
            m_done = 0;
        end else if (start && !abort) begin
            m_run = 1; m_t = 0; m_mode = int'(mode); m_dwell = int'(dwell);
        end
        #1;
        e = '0;
        if (m_run) begin
            k = m_t / (m_dwell + 1);
            p = pat_of(m_mode, k);
            e = {1'b0, 1'b1, 1'b1, |p, 4'(k), p};
        end else if (m_done) begin
            e = 12'h800;
        end
        cur = {d, c, b, a};
        o = {done, busy, valid, exp_or, idx, cur};
        check("outputs", 32'(o), 32'(e));
        if (done) done_cnt++;
        if (busy) busy_cnt++;
        if (valid && prev_valid && cur != prev_pat && $countones(cur ^ prev_pat) != 1)
            gray_bad++;
        prev_valid = valid;
        prev_pat   = cur;
        rst = 1'b0;
    endtask

    task automatic begin_run(input logic [1:0] md, input int dw);
        done_cnt = 0; busy_cnt = 0; gray_bad = 0;
        mode = md; dwell = DWELL_W'(dw); start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'b00; dwell = '0;
        m_run = 0; m_done = 0; m_t = 0; m_mode = 0; m_dwell = 0;
        done_cnt = 0; busy_cnt = 0; prev_pat = '0; prev_valid = 0; gray_bad = 0;
        cyc();
        check("reset_idx", 32'(idx), 32'd0);

        // Binary, dwell 0: 16 patterns, done on the 17th edge after start.
        begin_run(2'b00, 0);
        check("bin_first_exp_or", 32'(exp_or), 32'd0);
        repeat (16) cyc();
        check("bin_done_cnt", 32'(done_cnt), 32'd1);
        check("bin_busy_len", 32'(busy_cnt), 32'd16);
        cyc();

        // Walking-one, dwell 3: 4 patterns x 4 cycles.
        begin_run(2'b01, 3);
        repeat (16) cyc();
        check("walk_busy_len", 32'(busy_cnt), 32'd16);
        check("walk_done_cnt", 32'(done_cnt), 32'd1);
        cyc();

        // Gray, dwell 1: one bit changes per step, idx 5 -> 0111, last 1000.
        begin_run(2'b10, 1);
        repeat (10) cyc();
        check("gray_idx5_pat", 32'({d, c, b, a}), 32'h7);
        repeat (21) cyc();
        check("gray_last_pat", 32'({d, c, b, a}), 32'h8);
        repeat (2) cyc();
        check("gray_single_bit", 32'(gray_bad), 32'd0);

        // Abort on the 5th RUN cycle; then restart from idx 0.
        begin_run(2'b00, 0);
        repeat (3) cyc();
        abort = 1'b1; cyc(); abort = 1'b0;
        check("abort_valid", 32'(valid), 32'd0);
        repeat (20) cyc();
        check("abort_no_done", 32'(done_cnt), 32'd0);
        begin_run(2'b00, 0);
        check("restart_idx", 32'(idx), 32'd0);
        repeat (17) cyc();

        // Reset at idx 7, no done; start held through a run never restarts it.
        begin_run(2'b00, 0);
        repeat (7) cyc();
        check("pre_rst_idx", 32'(idx), 32'd7);
        rst = 1'b1; cyc();
        check("rst_busy", 32'(busy), 32'd0);
        repeat (20) cyc();
        check("rst_no_done", 32'(done_cnt), 32'd0);
        begin_run(2'b00, 0);
        start = 1'b1;
        repeat (15) cyc();
        start = 1'b0;
        cyc();
        check("start_held_done", 32'(done_cnt), 32'd1);
        cyc();

        // Dwell changed mid-run must not alter the hold.
        begin_run(2'b00, 2);
        repeat (5) cyc();
        dwell = 8'd9; mode = 2'b01;
        repeat (45) cyc();
        check("dwell_change_busy", 32'(busy_cnt), 32'd48);
        cyc();

        // All-ones dwell must not wrap.
        begin_run(2'b01, 255);
        repeat (1024) cyc();
        check("dwell_max_busy", 32'(busy_cnt), 32'd1024);
        cyc();

        // Randomized traffic against the model.
        repeat (4000) begin
            start = ($urandom_range(0, 3) == 0);
            abort = ($urandom_range(0, 60) == 0);
            rst   = ($urandom_range(0, 300) == 0);
            if ($urandom_range(0, 5) == 0) mode = 2'($urandom);
            if ($urandom_range(0, 5) == 0) dwell = DWELL_W'($urandom_range(0, 4));
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/or_stim_sequencer.md
OR_STIM_SEQUENCER -- requirements
Module: or_stim_sequencer

Interface
REQ-001 Parameter: DWELL_W, default 8, width of the per-pattern dwell count.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 Port: start  input  1  request to begin a sequence; sampled only in IDLE.
REQ-005 Port: abort  input  1  terminate the running sequence.
REQ-006 Port: mode  input  2  pattern set: 00 binary, 01 walking-one, 10 Gray, 11 binary.
REQ-007 Port: dwell  input  DWELL_W  cycles per pattern minus one.
REQ-008 Port: a, b, c, d  output  1 each  stimulus bits for the downstream four-input OR stage; a = pattern bit0, d = bit3.
REQ-009 Port: exp_or  output  1  expected OR result, a|b|c|d of the current pattern.
REQ-010 Port: valid  output  1  high while a/b/c/d carry a sequence pattern.
REQ-011 Port: busy  output  1  high in RUN.
REQ-012 Port: done  output  1  one-cycle completion pulse.
REQ-013 Port: idx  output  4  index of the current pattern within the sequence.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 All outputs SHALL be registered.
REQ-016 In IDLE, a sampled start=1 with abort=0 SHALL latch mode and dwell and enter RUN on the next edge, with idx=0 and the first pattern already driven on that edge (latency 1 cycle).
REQ-017 In RUN, mode and dwell input changes SHALL be ignored; only the latched copies SHALL be used.
REQ-018 Each pattern SHALL be held for exactly dwell+1 cycles; dwell=0 gives one cycle per pattern.
REQ-019 Binary mode SHALL emit 16 patterns with pattern = idx, 0x0 through 0xF.
REQ-020 Walking-one mode SHALL emit 4 patterns, 0x1, 0x2, 0x4, 0x8.
REQ-021 Gray mode SHALL emit 16 patterns with pattern = idx ^ (idx >> 1).
REQ-022 The dwell counter SHALL be DWELL_W bits wide and count up to the latched dwell; no wrap-around SHALL occur when dwell is all-ones.
REQ-023 After the last pattern's final dwell cycle, the next edge SHALL enter DONE.
REQ-024 In DONE: done=1, valid=0, busy=0, a..d=0, exp_or=0, idx=0; the next edge SHALL enter IDLE.
REQ-025 Total RUN duration SHALL be N*(dwell+1) cycles, where N is 16 or 4.
REQ-026 start asserted in RUN or DONE SHALL be ignored, with no queuing.
REQ-027 abort=1 in RUN SHALL force IDLE on the next edge with all outputs 0 and no done pulse.
REQ-028 If abort and start are both high in IDLE, abort SHALL win and the FSM SHALL stay in IDLE.
REQ-029 In IDLE: valid=0, busy=0, done=0, a..d=0, exp_or=0, idx=0.
REQ-030 exp_or SHALL update on the same edge as a..d and never lag them.

Reset
REQ-031 rst=1 at a rising edge SHALL force IDLE and clear all outputs, the latched mode, the latched dwell and the dwell counter, regardless of state.
REQ-032 rst SHALL take priority over start and abort.
REQ-033 Reset mid-RUN SHALL produce no done pulse.
REQ-034 After rst is released, a new start SHALL behave as in REQ-016.

Verification
REQ-035 The bench SHALL cover: binary mode, dwell=0, one-cycle start -> abcd=0000..1111 on 16 consecutive cycles, exp_or=0 only on the first, done high exactly on the 17th cycle after start was sampled.
REQ-036 The bench SHALL cover: walking-one mode, dwell=3 -> patterns 0001, 0010, 0100, 1000, each held 4 cycles, exp_or=1 throughout RUN, busy high for 16 cycles.
REQ-037 The bench SHALL cover: Gray mode, dwell=1 -> exactly one of a..d changes between successive patterns; idx=5 shows pattern 0111; the final pattern is 1000.
REQ-038 The bench SHALL cover: abort on the 5th RUN cycle of a binary run -> next cycle IDLE, abcd=0000, done never asserts; a following start restarts at idx=0.
REQ-039 The bench SHALL cover: rst asserted at idx=7 of a binary run -> all outputs 0 on the next edge, no done; start asserted while busy never extends or restarts a run.
REQ-040 The bench SHALL cover: dwell changed from 2 to 9 mid-run -> hold stays at 3 cycles per pattern.
